// File: rtl/binary_gray_converter.sv
// Registered binary-to-Gray encoder with a valid-qualified, single-stage pipeline.
// Define GRAY_DECODE_EN to add a registered Gray-to-binary decoder (gray_in -> binary_out).
module binary_gray_converter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] binary_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] gray_out
`ifdef GRAY_DECODE_EN
    ,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] binary_out
`endif
);

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] g;
        g[WIDTH-1] = b[WIDTH-1];
        for (int i = 0; i < WIDTH - 1; i++) begin
            g[i] = b[i+1] ^ b[i];
        end
        return g;
    endfunction

    logic [WIDTH-1:0] gray_q, gray_d;
    logic             valid_q, valid_d;

    // Select the held register unless accepting, so X on an idle binary_in never reaches gray_q.
    always_comb begin
        gray_d  = gray_q;
        valid_d = 1'b0;
        if (in_valid) begin
            gray_d  = bin2gray(binary_in);
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            gray_q  <= gray_d;
            valid_q <= valid_d;
        end
    end

    assign gray_out  = gray_q;
    assign out_valid = valid_q;

`ifdef GRAY_DECODE_EN
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] binary_q, binary_d;

    // The decoder free-runs every edge, independent of the encoder's valid handshake.
    always_comb begin
        binary_d = gray2bin(gray_in);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            binary_q <= '0;
        end else begin
            binary_q <= binary_d;
        end
    end

    assign binary_out = binary_q;
`endif

endmodule

// File: tb/tb_binary_gray_converter.sv
// Self-checking bench for binary_gray_converter (WIDTH = 8); decode checks enabled with GRAY_DECODE_EN.
module tb_binary_gray_converter;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] binary_in;
    logic         out_valid;
    logic [W-1:0] gray_out;
`ifdef GRAY_DECODE_EN
    logic [W-1:0] gray_in;
    logic [W-1:0] binary_out;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_gray;
    logic [W-1:0] prev_gray;
    logic [W-1:0] sweep_tab[16];

    binary_gray_converter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .binary_in (binary_in),
        .out_valid (out_valid),
        .gray_out  (gray_out)
`ifdef GRAY_DECODE_EN
        ,
        .gray_in   (gray_in),
        .binary_out(binary_out)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Reference model: Gray code as plain arithmetic, decode as XOR of all right shifts.
    function automatic logic [W-1:0] ref_enc(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [W-1:0] ref_dec(input logic [W-1:0] g);
        logic [W-1:0] acc = '0;
        for (int s = 0; s < W; s++) acc = acc ^ (g >> s);
        return acc;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver: apply one cycle of input at negedge, settle #1 after the following posedge.
    task automatic drive(input logic v, input logic [W-1:0] b);
        @(negedge clk);
        in_valid  = v;
        binary_in = b;
        if (v) model_gray = ref_enc(b);
        exp_q.push_back(model_gray);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare gray_out with the oldest expectation, plus out_valid.
    task automatic check_out(input string tag, input logic exp_valid);
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check({tag, "_gray"}, 32'(gray_out), 32'(e));
        check({tag, "_valid"}, 32'(out_valid), 32'(exp_valid));
    endtask

    initial begin
        sweep_tab = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04,
                      8'h0C, 8'h0D, 8'h0F, 8'h0E, 8'h0A, 8'h0B, 8'h09, 8'h08};
        rst        = 1'b1;
        in_valid   = 1'b0;
        binary_in  = '0;
        model_gray = '0;
`ifdef GRAY_DECODE_EN
        gray_in    = '0;
`endif
        #1;
        check("reset_gray", 32'(gray_out), 32'h0);
        check("reset_valid", 32'(out_valid), 32'h0);
`ifdef GRAY_DECODE_EN
        check("reset_binary_out", 32'(binary_out), 32'h0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Sweep 0..15 against the literal table, with single-bit-change check.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, W'(i));
            check($sformatf("sweep_tab_%0d", i), 32'(gray_out), 32'(sweep_tab[i]));
            check_out($sformatf("sweep_%0d", i), 1'b1);
            if (i > 0) check($sformatf("sweep_onebit_%0d", i), $countones(gray_out ^ prev_gray), 1);
            prev_gray = gray_out;
        end

        // Boundaries and wrap-around.
        drive(1'b1, 8'h7F); check("b7F", 32'(gray_out), 32'h40); check_out("b7F_sb", 1'b1);
        drive(1'b1, 8'h80); check("b80", 32'(gray_out), 32'hC0); check_out("b80_sb", 1'b1);
        drive(1'b1, 8'hFF); check("bFF", 32'(gray_out), 32'h80); check_out("bFF_sb", 1'b1);
        prev_gray = gray_out;
        drive(1'b1, 8'h00); check("b00", 32'(gray_out), 32'h00); check_out("b00_sb", 1'b1);
        check("wrap_onebit", $countones(gray_out ^ prev_gray), 1);

        // Hold: one accepted value then three idle cycles with junk on binary_in.
        drive(1'b1, 8'h05); check("hold_accept", 32'(gray_out), 32'h07); check_out("hold_acc_sb", 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'hAA);
            check($sformatf("hold_gray_%0d", i), 32'(gray_out), 32'h07);
            check_out($sformatf("hold_%0d", i), 1'b0);
        end

        // X on an idle input must not leak.
        drive(1'b0, 'x); check_out("x_idle", 1'b0);

        // Async reset mid-cycle while out_valid = 1.
        drive(1'b1, 8'h3C); check_out("pre_reset", 1'b1);
        #2;
        rst = 1'b1;
        model_gray = '0;
        exp_q.delete();
        #1;
        check("async_rst_gray", 32'(gray_out), 32'h0);
        check("async_rst_valid", 32'(out_valid), 32'h0);
        drive(1'b1, 8'h99);
        model_gray = '0;
        exp_q.delete();
        check("rst_held_gray", 32'(gray_out), 32'h0);
        check("rst_held_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("post_rst_no_stale", 32'(out_valid), 32'h0);
        check("post_rst_gray", 32'(gray_out), 32'h0);
        drive(1'b1, 8'h5A); check_out("post_rst_first", 1'b1);

        // Exhaustive encode, back-to-back.
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, W'(i));
            check_out($sformatf("exh_%0d", i), 1'b1);
        end

        // Randomized valid/data.
        for (int i = 0; i < 300; i++) begin
            logic v;
            v = 1'($urandom_range(0, 1));
            drive(v, W'($urandom));
            check_out($sformatf("rnd_%0d", i), v);
        end

`ifdef GRAY_DECODE_EN
        @(negedge clk); gray_in = 8'h80; in_valid = 1'b0;
        @(posedge clk); #1;
        check("dec_80", 32'(binary_out), 32'hFF);
        @(negedge clk); gray_in = 8'h0B;
        @(posedge clk); #1;
        check("dec_0B", 32'(binary_out), 32'h0D);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk); gray_in = ref_enc(W'(i));
            @(posedge clk); #1;
            check($sformatf("roundtrip_%0d", i), 32'(binary_out), 32'(i));
        end
        for (int i = 0; i < 50; i++) begin
            logic [W-1:0] g;
            g = W'($urandom);
            @(negedge clk); gray_in = g;
            @(posedge clk); #1;
            check($sformatf("dec_rnd_%0d", i), 32'(binary_out), 32'(ref_dec(g)));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
